counter_checker: RTL
====================

# counter_checker

Sequence checker for the free-running 8-bit `counter`. Samples the counter's `value` bus and the counter's own synchronous reset on every `clk` edge, predicts the next value, and reports lock status, per-cycle mismatch pulses, wrap events and saturating statistics. It sits beside the counter as its reader and is used both in self-checking benches and as an on-chip health monitor.

## Interface
- `WIDTH`, 8: width of the observed count.
- `ERR_W`, 16: width of the error and wrap statistic counters.
- `LOCK_RUN`, 2: consecutive correct increments required to (re)enter LOCKED; legal range 1..15.

- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset of all state.
- `value`  in  WIDTH  count bus from the counter.
- `cnt_reset`  in  1  the counter's synchronous reset, active-high, same signal the counter sees.
- `clr_stats`  in  1  synchronous clear of `err_count` and `wrap_count`.
- `locked`  out  1  checker is tracking the sequence.
- `error`  out  1  one-cycle pulse: mismatch detected while LOCKED.
- `wrap`  out  1  one-cycle pulse: correct WIDTH'hFF→0 rollover while LOCKED.
- `expected`  out  WIDTH  value predicted for the next edge.
- `err_count`  out  ERR_W  saturating mismatch count.
- `wrap_count`  out  ERR_W  saturating rollover count.

## Operation
- Prediction per edge: `expected` ← `cnt_reset` ? 0 : `value` + 1 (mod 2^WIDTH). Computed from the sample taken at that edge regardless of state.
- `match` at an edge = sampled `value` == registered `expected`.
- States:
  - UNLOCKED (reset state): first edge after reset loads `expected`, run counter ← 0, go ACQUIRE.
  - ACQUIRE: match → run+1; run reaching LOCK_RUN → LOCKED. Mismatch → run ← 0, stay.
  - LOCKED: match → stay. Mismatch → `error` pulse, `err_count`+1, run ← 0, go ACQUIRE.
- `wrap`: LOCKED, match, and `expected` was 0 due to rollover (previous sample WIDTH'hFF, `cnt_reset` low). A forced zero via `cnt_reset` is not a wrap.
- Counters saturate at all-ones; no further increment, no rollover.
- `clr_stats` wins over a simultaneous increment: counter reads 0 after the edge.
- `cnt_reset` is not an error source: a counter reset is predicted, so a locked checker stays locked through it.

## Timing
- All outputs registered. Reset values: `locked`=0, `error`=0, `wrap`=0, `expected`=0, `err_count`=0, `wrap_count`=0, state UNLOCKED.
- `error`/`wrap` are high exactly the one cycle following the offending edge; counters update on the same edge.
- `locked` rises on the edge that completes the LOCK_RUN-th match: with LOCK_RUN=2, on the third sampled edge after reset release (load, match, match). It falls on the mismatch edge, together with `error`.
- `reset_n` assertion mid-operation clears everything immediately (asynchronous). Release is sampled synchronously; the first rising edge with `reset_n` high is the load edge.
- Back-to-back mismatches produce only one `error` pulse; later mismatches in ACQUIRE are silent.

## Structure
- Shared package `counter_pkg`: WIDTH default, state enum `chk_state_t` {UNLOCKED, ACQUIRE, LOCKED}, saturating-increment function.
- One sub-module is natural: `sat_counter` (ERR_W, inc, clr), instantiated twice for `err_count` and `wrap_count`.

## Test plan
- Clean run: reset, then a free-running counter → `locked`=1 on the 3rd edge, `error` never set, `err_count`=0.
- Rollover: lock, run 0xFE→0xFF→0x00 → `wrap` pulses once, `wrap_count`=1, `locked` stays 1.
- Counter reset mid-run: pulse `cnt_reset` for 1 cycle at value 0x23 → next sample 0x00 matches, no `error`, no `wrap`.
- Glitch: force `value` to 0x55 for one cycle where 0x10 is expected → `error` one cycle, `err_count`=1, `locked`=0, relock two matches later.
- Saturation/clear: with ERR_W=2, inject 5 separate glitches → `err_count`=3. Assert `clr_stats` together with a 6th glitch → `err_count`=0.
- Async reset: drop `reset_n` mid-cycle while LOCKED → all outputs 0 before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequence checker: defaults, state
// encoding and the saturating increment used by the statistic counters.
package counter_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned ERR_W_DEF    = 16;
  localparam int unsigned LOCK_RUN_DEF = 2;

  // Run counter is wide enough for the largest legal LOCK_RUN (15).
  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } chk_state_t;

  // Increment that sticks at i_max instead of rolling over.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val,
                                          input logic [31:0] i_max);
    return (i_val >= i_max) ? i_max : i_val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter
  import counter_pkg::*;
#(
  parameter int unsigned ERR_W = ERR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [ERR_W-1:0] o_count
);

  localparam logic [ERR_W-1:0] ALL_ONES = '1;
  localparam logic [31:0]      MAX      = 32'(ALL_ONES);

  logic [ERR_W-1:0] r_count;

  // Count events, hold at all-ones, clear to zero on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= ERR_W'(sat_inc(32'(r_count), MAX));
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_checker.sv
// Sequence checker for a free-running counter: predicts the next count,
// tracks lock, and reports mismatch/rollover pulses and statistics.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   UNLOCKED | after reset; next edge only loads the prediction
//   ACQUIRE  | counting consecutive correct increments toward lock
//   LOCKED   | tracking; a mismatch pulses error and drops to ACQUIRE
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF,
  parameter int unsigned LOCK_RUN = LOCK_RUN_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_cnt_reset,
  input  logic             i_clr_stats,
  output logic             o_locked,
  output logic             o_error,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_expected,
  output logic [ERR_W-1:0] o_err_count,
  output logic [ERR_W-1:0] o_wrap_count
);

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_RUN);

  chk_state_t       r_state;
  chk_state_t       w_state_nxt;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_run_inc;

  logic [WIDTH-1:0] r_expected;
  logic             r_rollover;
  logic [WIDTH-1:0] w_expected_nxt;
  logic             w_rollover_nxt;
  logic             w_match;

  logic             r_locked;
  logic             r_error;
  logic             r_wrap;
  logic             w_locked_nxt;
  logic             w_error_nxt;
  logic             w_wrap_nxt;

  // A counter reset predicts zero; only an all-ones sample without reset
  // makes the coming zero a genuine rollover.
  assign w_match        = (i_value == r_expected);
  assign w_expected_nxt = i_cnt_reset ? '0 : i_value + WIDTH'(1);
  assign w_rollover_nxt = !i_cnt_reset && (i_value == ALL_ONES);
  assign w_run_inc      = r_run + RUN_W'(1);

  // State and run-length register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Next-state and run-length decision from the current match.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    unique case (r_state)
      UNLOCKED: begin
        w_state_nxt = ACQUIRE;
        w_run_nxt   = '0;
      end
      ACQUIRE: begin
        if (w_match) begin
          w_run_nxt = w_run_inc;
          if (w_run_inc >= RUN_TARGET) begin
            w_state_nxt = LOCKED;
          end
        end else begin
          w_run_nxt = '0;
        end
      end
      LOCKED: begin
        if (!w_match) begin
          w_state_nxt = ACQUIRE;
          w_run_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_run_nxt   = '0;
      end
    endcase
  end

  // Output decode; error and wrap are only reported while locked.
  always_comb begin
    w_locked_nxt = 1'b0;
    w_error_nxt  = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_locked_nxt = (w_state_nxt == LOCKED);
    if (r_state == LOCKED) begin
      w_error_nxt = !w_match;
      w_wrap_nxt  = w_match && r_rollover;
    end
  end

  // Prediction for the next edge, computed in every state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_expected <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_expected <= w_expected_nxt;
      r_rollover <= w_rollover_nxt;
    end
  end

  // Registered status outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_locked <= 1'b0;
      r_error  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_locked <= w_locked_nxt;
      r_error  <= w_error_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_count (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_inc   (w_error_nxt),
    .i_clr   (i_clr_stats),
    .o_count (o_err_count)
  );

  sat_counter #(.ERR_W(ERR_W)) u_wrap_count (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_inc   (w_wrap_nxt),
    .i_clr   (i_clr_stats),
    .o_count (o_wrap_count)
  );

  assign o_locked   = r_locked;
  assign o_error    = r_error;
  assign o_wrap     = r_wrap;
  assign o_expected = r_expected;

endmodule
